// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding,
// register offsets and fixed source indices.
package irq_ctrl_pkg;

  localparam int MAX_SRC = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] REG_MASK   = 2'd0;
  localparam logic [1:0] REG_MODE   = 2'd1;
  localparam logic [1:0] REG_PEND   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int SRC_TC1 = 0;
  localparam int SRC_TC2 = 1;
  localparam int SRC_EXT = 2;

endpackage

// File: rtl/irq_ctrl_if.sv
// Bus bundle between the CPU side (master) and the interrupt controller
// (slave): raw sources, register port, acknowledge and request outputs.
interface irq_ctrl_if #(parameter int NSRC = 6);
  import irq_ctrl_pkg::*;

  logic [NSRC-1:0]    irq_src;
  logic [1:0]         pr_addr;
  logic               pr_we;
  logic [31:0]        pr_wd;
  logic [31:0]        pr_rd;
  logic               int_ack;
  logic               irq_req;
  logic [2:0]         irq_id;
  logic [MAX_SRC-1:0] hwint;

  modport master (
    output irq_src, pr_addr, pr_we, pr_wd, int_ack,
    input  pr_rd, irq_req, irq_id, hwint
  );

  modport slave (
    input  irq_src, pr_addr, pr_we, pr_wd, int_ack,
    output pr_rd, irq_req, irq_id, hwint
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc #(
  parameter int NSRC = 6
) (
  input  logic [NSRC-1:0] req,
  output logic [2:0]      idx,
  output logic            valid
);

  // Scan from the top down so the lowest active index is the last to assign
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes raw sources, keeps MASK/MODE/PEND
// registers, and hands the highest-priority pending source to the CPU
// through a REQ/SERVICE/EOI handshake.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 6
) (
  input logic       clk,
  input logic       reset,
  irq_ctrl_if.slave bus
);

  logic [NSRC-1:0] sync1_q, sync1_d;
  logic [NSRC-1:0] sync2_q, sync2_d;
  logic [NSRC-1:0] sync3_q, sync3_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] pend_q, pend_d;
  state_e          state_q, state_d;
  logic            isr_valid_q, isr_valid_d;
  logic [2:0]      irq_id_q, irq_id_d;

  logic            wr_mask, wr_mode, wr_pend, wr_status;
  logic [NSRC-1:0] edge_det, active, ack_clr, clr;
  logic [2:0]      win_idx;
  logic            win_valid;
  logic            cur_active;
  logic            take_ack;
  logic            unused_wd;

  assign unused_wd = ^bus.pr_wd[31:NSRC];

  irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .req   (active),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // Register-port write decode and MASK/MODE updates
  always_comb begin
    wr_mask   = bus.pr_we && (bus.pr_addr == REG_MASK);
    wr_mode   = bus.pr_we && (bus.pr_addr == REG_MODE);
    wr_pend   = bus.pr_we && (bus.pr_addr == REG_PEND);
    wr_status = bus.pr_we && (bus.pr_addr == REG_STATUS);
    mask_d    = wr_mask ? bus.pr_wd[NSRC-1:0] : mask_q;
    mode_d    = wr_mode ? bus.pr_wd[NSRC-1:0] : mode_q;
  end

  // Two-stage synchronizer plus a third stage used only for edge detection
  always_comb begin
    sync1_d  = bus.irq_src;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    edge_det = sync2_q & ~sync3_q;
  end

  // Pending bits: edge sources latch with set-over-clear, level sources track the input
  always_comb begin
    pend_d = pend_q;
    clr    = ack_clr | (wr_pend ? bus.pr_wd[NSRC-1:0] : '0);
    for (int i = 0; i < NSRC; i++) begin
      if (mode_q[i]) begin
        pend_d[i] = (pend_q[i] & ~clr[i]) | edge_det[i];
      end else begin
        pend_d[i] = sync2_q[i];
      end
    end
  end

  // Whether the source currently latched in irq_id is still pending and enabled
  always_comb begin
    active     = pend_q & mask_q;
    cur_active = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (irq_id_q == 3'(i)) begin
        cur_active = active[i];
      end
    end
  end

  // FSM next state: withdrawal in REQ takes precedence over a same-cycle ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (win_valid) state_d = ST_REQ;
      ST_REQ: begin
        if (!cur_active)      state_d = ST_IDLE;
        else if (bus.int_ack) state_d = ST_SERVICE;
      end
      ST_SERVICE: if (wr_status) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: latch the winner on entry to REQ, track isr_valid, clear acked edge bit
  always_comb begin
    take_ack    = (state_q == ST_REQ) && cur_active && bus.int_ack;
    irq_id_d    = irq_id_q;
    isr_valid_d = isr_valid_q;
    if ((state_q == ST_IDLE) && win_valid) begin
      irq_id_d = win_idx;
    end
    if (take_ack) begin
      isr_valid_d = 1'b1;
    end
    if ((state_q == ST_SERVICE) && wr_status) begin
      isr_valid_d = 1'b0;
    end
    ack_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_clr[i] = take_ack && mode_q[i] && (irq_id_q == 3'(i));
    end
  end

  // All controller state, cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      mask_q      <= '0;
      mode_q      <= '0;
      pend_q      <= '0;
      state_q     <= ST_IDLE;
      isr_valid_q <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      isr_valid_q <= isr_valid_d;
      irq_id_q    <= irq_id_d;
    end
  end

  // Outputs: request decoded from the state flop, register read mux, HWInt vector
  always_comb begin
    bus.irq_req = (state_q == ST_REQ);
    bus.irq_id  = irq_id_q;
    bus.hwint   = MAX_SRC'(active);
    case (bus.pr_addr)
      REG_MASK: bus.pr_rd = 32'(mask_q);
      REG_MODE: bus.pr_rd = 32'(mode_q);
      REG_PEND: bus.pr_rd = 32'(pend_q);
      default:  bus.pr_rd = {26'b0, state_q, isr_valid_q, irq_id_q};
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: level, edge, priority,
// withdrawal, W1C/edge collision and asynchronous reset scenarios.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  irq_ctrl_if #(.NSRC(6)) bus ();

  irq_ctrl #(.NSRC(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 20 ns clock
  always #10 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one cycle of register/ack activity, then return the bus to idle
  task automatic applyStimulus(input logic [1:0] addr, input logic we,
                               input logic [31:0] wd, input logic ack);
    bus.pr_addr = addr;
    bus.pr_we   = we;
    bus.pr_wd   = wd;
    bus.int_ack = ack;
    tick(1);
    bus.pr_we   = 1'b0;
    bus.pr_wd   = '0;
    bus.int_ack = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] wd);
    applyStimulus(addr, 1'b1, wd, 1'b0);
  endtask

  task automatic ackCpu();
    applyStimulus(REG_MASK, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic checkReg(input string tag, input logic [1:0] addr,
                          input logic [31:0] expected);
    bus.pr_addr = addr;
    #1;
    checkOutput(tag, bus.pr_rd, expected);
  endtask

  // One-cycle pulse on the given source bits
  task automatic pulseSrc(input logic [5:0] bits);
    bus.irq_src = bits;
    tick(1);
    bus.irq_src = '0;
  endtask

  initial begin
    reset       = 1'b0;
    bus.irq_src = '0;
    bus.pr_addr = '0;
    bus.pr_we   = 1'b0;
    bus.pr_wd   = '0;
    bus.int_ack = 1'b0;

    // Reset state
    #3;
    checkOutput("rst_irq_req", 32'(bus.irq_req), 32'h0);
    checkOutput("rst_irq_id", 32'(bus.irq_id), 32'h0);
    checkOutput("rst_hwint", 32'(bus.hwint), 32'h0);
    for (int a = 0; a < 4; a++) begin
      checkReg($sformatf("rst_reg%0d", a), 2'(a), 32'h0);
    end
    tick(2);
    reset = 1'b1;

    // Level source 0: 4-edge latency, ack, EOI with the level still high
    writeReg(REG_MASK, 32'h01);
    bus.irq_src = 6'h01 << SRC_TC1;
    tick(3);
    checkOutput("lvl_lat3", 32'(bus.irq_req), 32'h0);
    tick(1);
    checkOutput("lvl_lat4", 32'(bus.irq_req), 32'h1);
    checkOutput("lvl_id", 32'(bus.irq_id), 32'h0);
    checkOutput("lvl_hwint", 32'(bus.hwint), 32'h01);
    checkReg("lvl_status_req", REG_STATUS, 32'h10);
    ackCpu();
    checkReg("lvl_status_svc", REG_STATUS, 32'h28);
    checkOutput("lvl_svc_req", 32'(bus.irq_req), 32'h0);
    writeReg(REG_PEND, 32'h01);
    checkReg("lvl_w1c_noeffect", REG_PEND, 32'h01);
    checkOutput("lvl_svc_hold", 32'(bus.irq_req), 32'h0);
    writeReg(REG_STATUS, 32'h0);
    checkReg("lvl_eoi_status", REG_STATUS, 32'h00);
    checkOutput("lvl_eoi_req", 32'(bus.irq_req), 32'h0);
    tick(1);
    checkOutput("lvl_rereq", 32'(bus.irq_req), 32'h1);
    bus.irq_src = '0;
    tick(6);
    checkOutput("lvl_drop_req", 32'(bus.irq_req), 32'h0);
    checkReg("lvl_drop_status", REG_STATUS, 32'h00);

    // Edge source 1: single pulse latches PEND, ack clears it
    writeReg(REG_MODE, 32'h02);
    writeReg(REG_MASK, 32'h02);
    pulseSrc(6'h01 << SRC_TC2);
    tick(2);
    checkReg("edge_pend", REG_PEND, 32'h02);
    checkOutput("edge_hwint", 32'(bus.hwint), 32'h02);
    checkOutput("edge_req_early", 32'(bus.irq_req), 32'h0);
    tick(1);
    checkOutput("edge_req", 32'(bus.irq_req), 32'h1);
    checkOutput("edge_id", 32'(bus.irq_id), 32'h1);
    ackCpu();
    checkReg("edge_pend_ack", REG_PEND, 32'h00);
    checkReg("edge_status_svc", REG_STATUS, 32'h29);
    writeReg(REG_STATUS, 32'h0);
    tick(2);
    checkOutput("edge_idle_req", 32'(bus.irq_req), 32'h0);
    checkReg("edge_idle_status", REG_STATUS, 32'h01);

    // Priority: sources 0 and 2 together, 0 wins, 2 follows after EOI
    writeReg(REG_MODE, 32'h05);
    writeReg(REG_MASK, 32'h05);
    pulseSrc((6'h01 << SRC_TC1) | (6'h01 << SRC_EXT));
    tick(3);
    checkOutput("prio_req", 32'(bus.irq_req), 32'h1);
    checkOutput("prio_id0", 32'(bus.irq_id), 32'h0);
    checkReg("prio_pend", REG_PEND, 32'h05);
    ackCpu();
    checkReg("prio_pend_ack", REG_PEND, 32'h04);
    checkReg("prio_status_svc", REG_STATUS, 32'h28);
    tick(1);
    checkOutput("prio_svc_ignore", 32'(bus.irq_req), 32'h0);
    writeReg(REG_STATUS, 32'h0);
    tick(1);
    checkOutput("prio_req2", 32'(bus.irq_req), 32'h1);
    checkOutput("prio_id2", 32'(bus.irq_id), 32'h2);
    ackCpu();
    checkReg("prio_pend_clear", REG_PEND, 32'h00);
    writeReg(REG_STATUS, 32'h0);

    // Withdrawal: mask dropped in REQ, a following ack is ignored
    writeReg(REG_MASK, 32'h01);
    pulseSrc(6'h01 << SRC_TC1);
    tick(3);
    checkOutput("wd_req", 32'(bus.irq_req), 32'h1);
    writeReg(REG_MASK, 32'h00);
    ackCpu();
    checkOutput("wd_req_low", 32'(bus.irq_req), 32'h0);
    checkReg("wd_status", REG_STATUS, 32'h00);
    checkReg("wd_pend_kept", REG_PEND, 32'h01);
    checkOutput("wd_hwint", 32'(bus.hwint), 32'h0);
    ackCpu();
    checkReg("idle_ack_ignored", REG_PEND, 32'h01);
    writeReg(REG_PEND, 32'h01);
    checkReg("w1c_edge", REG_PEND, 32'h00);

    // Collision: W1C on the same cycle a new edge is detected
    writeReg(REG_MODE, 32'h02);
    pulseSrc(6'h01 << SRC_TC2);
    tick(4);
    checkReg("coll_pend_first", REG_PEND, 32'h02);
    pulseSrc(6'h01 << SRC_TC2);
    tick(1);
    writeReg(REG_PEND, 32'h02);
    checkReg("coll_set_wins", REG_PEND, 32'h02);
    writeReg(REG_PEND, 32'h02);
    checkReg("coll_w1c_alone", REG_PEND, 32'h00);

    // Asynchronous reset during SERVICE, then restart latency
    writeReg(REG_MODE, 32'h00);
    writeReg(REG_MASK, 32'h04);
    bus.irq_src = 6'h01 << SRC_EXT;
    tick(4);
    checkOutput("rst_pre_req", 32'(bus.irq_req), 32'h1);
    checkOutput("rst_pre_id", 32'(bus.irq_id), 32'h2);
    ackCpu();
    checkReg("rst_pre_status", REG_STATUS, 32'h2A);
    checkOutput("rst_pre_hwint", 32'(bus.hwint), 32'h04);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_irq_req", 32'(bus.irq_req), 32'h0);
    checkOutput("arst_irq_id", 32'(bus.irq_id), 32'h0);
    checkOutput("arst_hwint", 32'(bus.hwint), 32'h0);
    checkReg("arst_status", REG_STATUS, 32'h0);
    checkReg("arst_mask", REG_MASK, 32'h0);
    checkReg("arst_pend", REG_PEND, 32'h0);
    tick(1);
    reset = 1'b1;
    writeReg(REG_MASK, 32'h04);
    tick(2);
    checkOutput("post_rst_lat3", 32'(bus.irq_req), 32'h0);
    tick(1);
    checkOutput("post_rst_lat4", 32'(bus.irq_req), 32'h1);
    bus.irq_src = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter NSRC, default 6, giving the number of interrupt sources (max 6).
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-003 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port irq_src, input, NSRC bits, raw asynchronous sources: bit0 TC1, bit1 TC2, bit2 external interrupt, bits 5:3 spare.
REQ-005 The block SHALL have port pr_addr, input, 2 bits, the register select taken from word address bits [3:2].
REQ-006 The block SHALL have port pr_we, input, 1 bit, the register write strobe.
REQ-007 The block SHALL have port pr_wd, input, 32 bits, the write data.
REQ-008 The block SHALL have port pr_rd, output, 32 bits, the read data (combinational).
REQ-009 The block SHALL have port int_ack, input, 1 bit, a one-cycle CPU acknowledge pulse.
REQ-010 The block SHALL have port irq_req, output, 1 bit, the registered interrupt request to the CPU.
REQ-011 The block SHALL have port irq_id, output, 3 bits, the index of the requested or in-service source.
REQ-012 The block SHALL have port hwint, output, 6 bits, equal to PEND & MASK zero-extended, for the CPU HWInt input.

Function
REQ-013 Each irq_src bit SHALL pass a 2-flop synchronizer; edge detection SHALL be sync2 & ~sync3.
REQ-014 Registers SHALL be: addr 0 MASK (RW); addr 1 MODE (RW, 1 = edge, 0 = level); addr 2 PEND (read; write-1-clear applies to edge bits only); addr 3 STATUS (read {26'b0, state[1:0], isr_valid, irq_id[2:0]}; any write = EOI).
REQ-015 For an edge source, PEND[i] SHALL set on a detected edge and clear on W1C or on ack of source i; if set and clear occur in the same cycle, set SHALL win.
REQ-016 For a level source, PEND[i] SHALL follow the synchronized level each cycle; W1C SHALL have no effect.
REQ-017 Priority SHALL be fixed, with the lowest index highest.
REQ-018 The FSM SHALL have states IDLE(0), REQ(1) and SERVICE(2).
REQ-019 In IDLE, if (PEND & MASK) != 0, the FSM SHALL go to REQ and latch irq_id as the highest-priority active source.
REQ-020 In REQ, irq_req SHALL be 1 and irq_id SHALL stay stable (no preemption); on int_ack the FSM SHALL go to SERVICE, set isr_valid, and clear PEND[irq_id] if that source is edge-mode.
REQ-021 In REQ, if PEND[irq_id] & MASK[irq_id] drops before ack, the FSM SHALL return to IDLE with irq_req low next cycle; if int_ack arrives in that same cycle, the withdrawal SHALL win and the ack SHALL be ignored.
REQ-022 In SERVICE, irq_req SHALL be 0 and the FSM SHALL ignore new requests; a write to addr 3 SHALL clear isr_valid and return the FSM to IDLE.
REQ-023 int_ack outside REQ and EOI outside SERVICE SHALL be ignored.
REQ-024 Latency from an irq_src edge (setup met) to irq_req=1 SHALL be 4 clk rising edges when in IDLE with the source unmasked.
REQ-025 hwint SHALL be combinational from the PEND and MASK registers; bits at or above NSRC SHALL read 0.

Reset
REQ-026 While reset=0, asynchronously: MASK=0, MODE=0, PEND=0, synchronizers=0, state=IDLE, isr_valid=0, irq_id=0, irq_req=0, hwint=0.
REQ-027 Reset asserted mid-request or mid-service SHALL abandon the transaction; after release, the first possible irq_req SHALL occur no earlier than 4 edges later.

Structure
REQ-028 Shared package: state encoding IDLE/REQ/SERVICE, register offsets MASK=0, MODE=1, PEND=2, STATUS=3, and source indices TC1=0, TC2=1, EXT=2.
REQ-029 One sub-module, irq_prio_enc (NSRC-bit priority encoder to 3-bit index plus valid), is natural; everything else SHALL be flat.

Verification
REQ-030 Level test: MASK=0x01, MODE=0, irq_src[0] held high -> irq_req=1 after 4 edges with irq_id=0; ack -> STATUS state=2; EOI while still high -> re-request 1 edge after IDLE.
REQ-031 Edge test: MODE=0x02, MASK=0x02, 1-cycle pulse on irq_src[1] -> PEND=0x02 and hwint=0x02; after ack -> PEND=0x00.
REQ-032 Priority test: edge-mode sources 2 and 0 pulse in the same cycle, MASK=0x05 -> irq_id=0; after ack and EOI -> second request with irq_id=2.
REQ-033 Withdrawal test: in REQ for source 0, write MASK=0 -> irq_req=0 the next cycle, state=IDLE, PEND bit unchanged.
REQ-034 Collision test: W1C of PEND bit 1 in the same cycle as a new edge on source 1 -> PEND bit 1 stays 1.
REQ-035 Reset test: assert reset=0 during SERVICE -> all outputs 0 immediately, without waiting for a clk edge.
